// File: rtl/rns_pkg.sv
// rns_pkg: width helpers and modulus/period table for the RNS forward converters.
package rns_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Number of PERIOD-bit groups covering a w-bit word (NUM_G, NUM_G1).
    function automatic int num_groups(input int w, input int p);
        return (w + p - 1) / p;
    endfunction

    // Width of the sum of those groups (SUM_SIZE, F_SIZE).
    function automatic int fold_width(input int w, input int p);
        return p + clog2(num_groups(w, p));
    endfunction

    function automatic int period_of(input int m);
        return m == 21 ? 6 : m == 31 ? 5 : m == 17 ? 8 : m == 13 ? 12 : 0;
    endfunction

endpackage

// File: rtl/rns_fwd_conv_pipe_fold.sv
// rns_fold_sum: adds the zero-extended PERIOD-bit groups of din.
module rns_fold_sum
    import rns_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int PERIOD = 6,
    localparam int OUT_W = fold_width(IN_W, PERIOD)
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] sum
);
    localparam int NG = num_groups(IN_W, PERIOD);

    logic [NG*PERIOD-1:0] ext;

    assign ext = (NG*PERIOD)'(din);

    always_comb begin
        sum = '0;
        for (int i = 0; i < NG; i++) sum = sum + OUT_W'(ext[i*PERIOD +: PERIOD]);
    end
endmodule

// File: rtl/rns_fwd_conv_pipe.sv
// rns_fwd_conv_pipe: 3-stage binary-to-residue converter (fold, fold, exact correction)
// with valid/ready backpressure and a sideband tag.
module rns_fwd_conv_pipe
    import rns_pkg::*;
#(
    parameter int N_SIZE = 16,
    parameter int MOD    = 21,
    parameter int PERIOD = 6,
    parameter int TAG_W  = 4,
    localparam int RES_W = clog2(MOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_SIZE-1:0] N,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] residue,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SUM_SIZE = fold_width(N_SIZE, PERIOD);
    localparam int F_SIZE   = fold_width(SUM_SIZE, PERIOD);
    localparam int KMAX     = ((1 << F_SIZE) - 1) / MOD;

    if (MOD < 3 || MOD % 2 == 0 || (64'd1 << PERIOD) % 64'(MOD) != 64'd1) begin : g_bad_period
        $fatal(1, "rns_fwd_conv_pipe: 2^%0d mod %0d != 1", PERIOD, MOD);
    end
    if (F_SIZE > PERIOD + 1) begin : g_bad_width
        $fatal(1, "rns_fwd_conv_pipe: F_SIZE %0d exceeds PERIOD+1", F_SIZE);
    end

    logic [SUM_SIZE-1:0] fold1, s1_sum_q, s1_sum_d;
    logic [F_SIZE-1:0]   fold2, s2_sum_q, s2_sum_d, red;
    logic [TAG_W-1:0]    s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d, out_tag_q, out_tag_d;
    logic [RES_W-1:0]    residue_q, residue_d;
    logic                s1_v_q, s1_v_d, s2_v_q, s2_v_d, out_v_q, out_v_d;
    logic                adv1, adv2, adv3;

    rns_fold_sum #(.IN_W(N_SIZE), .PERIOD(PERIOD)) u_fold1 (.din(N), .sum(fold1));
    rns_fold_sum #(.IN_W(SUM_SIZE), .PERIOD(PERIOD)) u_fold2 (.din(s1_sum_q), .sum(fold2));

    always_comb begin
        adv3 = !out_v_q || out_ready;
        adv2 = !s2_v_q || adv3;
        adv1 = !s1_v_q || adv2;
        // Highest matching multiple wins; all compares run in parallel.
        red = s2_sum_q;
        for (int k = 1; k <= KMAX; k++)
            if (s2_sum_q >= F_SIZE'(k * MOD)) red = s2_sum_q - F_SIZE'(k * MOD);
        s1_v_d    = adv1 ? in_valid : s1_v_q;
        s1_sum_d  = (adv1 && in_valid) ? fold1 : s1_sum_q;
        s1_tag_d  = (adv1 && in_valid) ? in_tag : s1_tag_q;
        s2_v_d    = adv2 ? s1_v_q : s2_v_q;
        s2_sum_d  = (adv2 && s1_v_q) ? fold2 : s2_sum_q;
        s2_tag_d  = (adv2 && s1_v_q) ? s1_tag_q : s2_tag_q;
        out_v_d   = adv3 ? s2_v_q : out_v_q;
        residue_d = (adv3 && s2_v_q) ? RES_W'(red) : residue_q;
        out_tag_d = (adv3 && s2_v_q) ? s2_tag_q : out_tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_sum_q  <= '0;
            s1_tag_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_sum_q  <= '0;
            s2_tag_q  <= '0;
            out_v_q   <= 1'b0;
            residue_q <= '0;
            out_tag_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_sum_q  <= s1_sum_d;
            s1_tag_q  <= s1_tag_d;
            s2_v_q    <= s2_v_d;
            s2_sum_q  <= s2_sum_d;
            s2_tag_q  <= s2_tag_d;
            out_v_q   <= out_v_d;
            residue_q <= residue_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = out_v_q;
    assign residue   = residue_q;
    assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_rns_fwd_conv_pipe.sv
// tb_rns_fwd_conv_pipe: scoreboard bench for the MOD 21 converter plus MOD 31 / MOD 13 variants.
module tb_rns_fwd_conv_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] n = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid;
    logic [4:0]  residue;
    logic [3:0]  out_tag;

    logic        a_valid = 1'b0;
    logic [23:0] a_n = '0;
    logic        a31_ready, a31_valid, a13_ready, a13_valid;
    logic [4:0]  a31_res;
    logic [3:0]  a13_res, a31_tag, a13_tag;

    int n_assert = 0;
    int n_fail = 0;
    int n_out = 0;
    int a_out = 0;

    typedef struct {
        logic [4:0] r;
        logic [3:0] t;
    } exp_t;
    exp_t        sb[$];
    logic [23:0] aq[$];

    always #5 clk = ~clk;

    rns_fwd_conv_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .N(n),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .residue(residue), .out_tag(out_tag)
    );

    rns_fwd_conv_pipe #(.N_SIZE(24), .MOD(31), .PERIOD(5), .TAG_W(4)) dut31 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a31_ready), .N(a_n),
        .in_tag(4'd0), .out_valid(a31_valid), .out_ready(1'b1),
        .residue(a31_res), .out_tag(a31_tag)
    );

    rns_fwd_conv_pipe #(.N_SIZE(24), .MOD(13), .PERIOD(12), .TAG_W(4)) dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a13_ready), .N(a_n),
        .in_tag(4'd0), .out_valid(a13_valid), .out_ready(1'b1),
        .residue(a13_res), .out_tag(a13_tag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change only just after posedge, so the negedge sees what the next edge transfers.
    always @(negedge clk) if (rst_n) begin
        if (in_valid && in_ready) sb.push_back('{5'(n % 16'd21), in_tag});
        if (out_valid) begin
            chk("range", 32'(residue < 5'd21), 1);
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                chk("residue", residue, sb[0].r);
                chk("tag", out_tag, sb[0].t);
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_out++;
                end
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (a_valid && a31_ready) aq.push_back(a_n);
        if (a31_valid) begin
            chk("alt_nonempty", 32'(aq.size() != 0), 1);
            chk("alt13_valid", a13_valid, 1);
            if (aq.size() != 0) begin
                chk("res_mod31", a31_res, aq[0] % 24'd31);
                chk("res_mod13", a13_res, aq[0] % 24'd13);
                void'(aq.pop_front());
                a_out++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [15:0] v, input logic [3:0] t, input logic [4:0] exp_r);
        n = v;
        in_tag = t;
        in_valid = 1'b1;
        chk("single_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("lat1", out_valid, 0);
        step();
        chk("lat2", out_valid, 0);
        step();
        chk("lat3", out_valid, 1);
        chk("single_res", residue, exp_r);
        chk("single_tag", out_tag, t);
        step();
    endtask

    initial begin
        int acc, cyc, o0;
        logic [23:0] specials[3];
        specials[0] = 24'h00FFFF;
        specials[1] = 24'hFFFFFF;
        specials[2] = 24'h007FFF;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_residue", residue, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        single(16'd0, 4'd1, 5'd0);
        single(16'd20, 4'd2, 5'd20);
        single(16'd21, 4'd3, 5'd0);
        single(16'd63, 4'd4, 5'd0);
        single(16'd64, 4'd5, 5'd1);
        single(16'd1000, 4'd6, 5'd13);
        single(16'hFFFF, 4'd7, 5'd15);

        o0 = n_out;
        for (int i = 0; i < 1024; i++) begin
            n = 16'(i);
            in_tag = 4'(i);
            in_valid = 1'b1;
            @(negedge clk);
            chk("stream_ready", in_ready, 1);
            if (i >= 3) chk("stream_valid", out_valid, 1);
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        chk("stream_count", n_out - o0, 1024);
        chk("stream_drained", sb.size(), 0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            n = 16'(100 + acc * 37);
            in_tag = 4'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            step();
        end
        chk("bp_accepts", acc, 3);
        chk("bp_ready", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        chk("bp_drained", sb.size(), 0);

        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 40000) begin
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            n = 16'($urandom);
            in_tag = 4'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            step();
            cyc++;
        end
        chk("rand_accepts", acc, 10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        chk("rand_drained", sb.size(), 0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 16'(500 + i);
            in_tag = 4'(i);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_residue", residue, 0);
        chk("mid_rst_tag", out_tag, 0);
        sb.delete();
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        single(16'd1000, 4'd9, 5'd13);
        repeat (3) step();
        chk("post_rst_drained", sb.size(), 0);

        a_valid = 1'b1;
        for (int i = 0; i < 4099; i++) begin
            a_n = (i < 4096) ? 24'(i) : specials[i - 4096];
            step();
        end
        a_valid = 1'b0;
        repeat (5) step();
        chk("alt_count", a_out, 4099);
        chk("alt_drained", aq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
